div_issue_ctrl: RTL and testbench
=================================

# div_issue_ctrl

EX-stage initiator for the multi-cycle divider. It detects DIV/DIVU in EX, latches the operands, and drives the divider's start/annul handshake. It stalls the pipeline until the result arrives, then writes quotient/remainder to LO/HI with a one-cycle write pulse. It also handles flush and a watchdog timeout so the divider is never left mid-operation or re-triggered early.

## Interface
- TIMEOUT_CYCLES, 48: maximum WAIT cycles before forced abort.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-low.
- op_i  in  6  EX-stage ALU control; `DIV_CONTROL` / `DIVU_CONTROL` request a divide.
- opdata1_i  in  32  dividend (rs).
- opdata2_i  in  32  divisor (rt).
- flush_i  in  1  pipeline flush; kills any divide not yet written.
- div_ready_i  in  1  divider result-ready.
- div_result_i  in  64  divider result; [63:32] remainder, [31:0] quotient.
- div_start_o  out  1  divider start (`DivStart`=1, `DivStop`=0).
- div_annul_o  out  1  divider annul.
- div_op_o  out  6  latched op to divider.
- div_opdata1_o / div_opdata2_o  out  32 each  latched operands to divider.
- stall_req_o  out  1  EX stall request.
- hilo_we_o  out  1  HI/LO write enable, one-cycle pulse.
- hi_o / lo_o  out  32 each  remainder / quotient.
- div_err_o  out  1  sticky watchdog-timeout flag.

## Operation
- div_req = (op_i == `DIV_CONTROL` or `DIVU_CONTROL`) and !flush_i.
- States: IDLE, WAIT, DONE.
- IDLE:
  - On div_req, latch op_i, opdata1_i, opdata2_i into div_op_o and div_opdata*_o, clear the watchdog counter, and go to WAIT.
  - div_start_o is never asserted in IDLE.
- WAIT:
  - div_start_o = 1 (combinational from state); div_annul_o = flush_i.
  - If flush_i: go to IDLE. No HI/LO write. Flush wins over a same-cycle div_ready_i.
  - Else if div_ready_i: register hi_o = div_result_i[63:32] and lo_o = div_result_i[31:0], then go to DONE.
  - Else if the counter reaches TIMEOUT_CYCLES-1: assert div_annul_o for this cycle, set div_err_o, and go to IDLE.
  - Otherwise increment the counter.
- DONE:
  - hilo_we_o = 1 and div_start_o = 0. This releases the divider from `DivEnd` to `DivFree`.
  - Always go to IDLE next. The DONE write is not cancelled by flush_i.
  - A new div_req seen in DONE is not accepted; it is stalled and taken from IDLE.
- stall_req_o = (IDLE and div_req) or (WAIT and !div_ready_i and !flush_i) or (DONE and div_req).
- div_op_o, div_opdata*_o and hi_o/lo_o hold their values until the next load.
- Divide-by-zero is not special-cased here: the divider returns 0. HI=0 and LO=0 are written.
- Sign handling is done by the divider; this block passes the op through unchanged.

## Timing
- Reset (rst=0 at edge): state IDLE. All outputs 0, including div_err_o and the counter.
- Request accepted in cycle T0 (IDLE): WAIT starts at T1, and the divider samples start at the end of T1.
- Nonzero divisor with the companion divider: div_ready_i is seen in the 36th WAIT cycle. hilo_we_o pulses one cycle later (DONE).
  - stall_req_o is high from T0 through the 35th WAIT cycle and low in the cycle div_ready_i is seen.
- Zero divisor: div_ready_i is seen in the 4th WAIT cycle.
- Back-to-back divides: the second divide accepted from IDLE starts ≥2 cycles after the first div_ready_i. The divider is in `DivFree` before start is re-asserted.
- Reset mid-WAIT: returns to IDLE and drops start. The divider is reset by the same rst.

## Test plan
- DIVU 7/2: hilo_we_o pulses once; hi_o=1, lo_o=3; stall high 36 cycles; stall_req_o low in the ready cycle.
- DIV −7/2 (0xFFFFFFF9, 2): lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF.
- DIV x/0: ready after 4 WAIT cycles; hi_o=lo_o=0; hilo_we_o pulses once.
- Flush at WAIT cycle 10: div_annul_o=1 that cycle; no hilo_we_o pulse; state IDLE. A following DIVU 9/3 yields lo=3, hi=0.
- Back-to-back DIVU 100/7 then DIVU 50/5: two separate pulses give (hi=2, lo=14) then (hi=0, lo=10). div_start_o is low ≥1 cycle between them.
- div_ready_i forced low (TIMEOUT_CYCLES=48): annul pulse in WAIT cycle 48, div_err_o=1 sticky, no write; then rst=0 clears it.

Source files
------------

// File: rtl/div_issue_ctrl_if.sv
// Handshake between the EX-stage divide initiator and the multi-cycle divider.
// The master side issues start/annul with latched operands; the slave returns ready and result.
interface div_issue_ctrl_if #(
    parameter int DATA_W = 32
);
    logic                  div_start_o;
    logic                  div_annul_o;
    logic [5:0]            div_op_o;
    logic [DATA_W-1:0]     div_opdata1_o;
    logic [DATA_W-1:0]     div_opdata2_o;
    logic                  div_ready_i;
    logic [2*DATA_W-1:0]   div_result_i;

    modport master (
        output div_start_o,
        output div_annul_o,
        output div_op_o,
        output div_opdata1_o,
        output div_opdata2_o,
        input  div_ready_i,
        input  div_result_i
    );

    modport slave (
        input  div_start_o,
        input  div_annul_o,
        input  div_op_o,
        input  div_opdata1_o,
        input  div_opdata2_o,
        output div_ready_i,
        output div_result_i
    );
endinterface

// File: rtl/div_issue_ctrl.sv
// EX-stage initiator for the multi-cycle divider: latches operands, holds start until the
// result arrives, writes HI/LO with a one-cycle pulse, and aborts on flush or watchdog timeout.
module div_issue_ctrl #(
    parameter int         DATA_W         = 32,
    parameter int         TIMEOUT_CYCLES = 48,
    parameter logic [5:0] DIV_CONTROL    = 6'b011010,
    parameter logic [5:0] DIVU_CONTROL   = 6'b011011
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        op_i,
    input  logic [DATA_W-1:0] opdata1_i,
    input  logic [DATA_W-1:0] opdata2_i,
    input  logic              flush_i,
    div_issue_ctrl_if.master  div,
    output logic              stall_req_o,
    output logic              hilo_we_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              div_err_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  wd_cnt;
    logic              start_q;
    logic [5:0]        op_q;
    logic [DATA_W-1:0] opdata1_q;
    logic [DATA_W-1:0] opdata2_q;
    logic              div_req;
    logic              wd_hit;

    assign div_req = ((op_i == DIV_CONTROL) || (op_i == DIVU_CONTROL)) && !flush_i;
    assign wd_hit  = (wd_cnt == WD_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            wd_cnt    <= '0;
            start_q   <= 1'b0;
            hilo_we_o <= 1'b0;
            div_err_o <= 1'b0;
            op_q      <= '0;
            opdata1_q <= '0;
            opdata2_q <= '0;
            hi_o      <= '0;
            lo_o      <= '0;
        end else begin
            hilo_we_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (div_req) begin
                        op_q      <= op_i;
                        opdata1_q <= opdata1_i;
                        opdata2_q <= opdata2_i;
                        wd_cnt    <= '0;
                        start_q   <= 1'b1;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Flush outranks a same-cycle ready so a killed divide never writes HI/LO.
                    if (flush_i) begin
                        start_q <= 1'b0;
                        state   <= S_IDLE;
                    end else if (div.div_ready_i) begin
                        hi_o      <= div.div_result_i[2*DATA_W-1:DATA_W];
                        lo_o      <= div.div_result_i[DATA_W-1:0];
                        start_q   <= 1'b0;
                        hilo_we_o <= 1'b1;
                        state     <= S_DONE;
                    end else if (wd_hit) begin
                        div_err_o <= 1'b1;
                        start_q   <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    // Start stays low here so the divider falls back to its free state
                    // before any following request can raise it again.
                    state <= S_IDLE;
                end
                default: begin
                    start_q <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    assign div.div_start_o   = start_q;
    assign div.div_annul_o   = (state == S_WAIT) &&
                               (flush_i || (!div.div_ready_i && wd_hit));
    assign div.div_op_o      = op_q;
    assign div.div_opdata1_o = opdata1_q;
    assign div.div_opdata2_o = opdata2_q;

    assign stall_req_o = ((state == S_IDLE) && div_req) ||
                         ((state == S_WAIT) && !div.div_ready_i && !flush_i) ||
                         ((state == S_DONE) && div_req);

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl with a behavioural divider; HI/LO writes are checked against a
// scoreboard of expected results queued when each divide is issued.
module tb_div_issue_ctrl;

    localparam logic [5:0] OP_DIV  = 6'b011010;
    localparam logic [5:0] OP_DIVU = 6'b011011;
    localparam logic [5:0] OP_NOP  = 6'b000000;

    logic        clk;
    logic        rst;
    logic [5:0]  op_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        flush_i;
    logic        stall_req_o;
    logic        hilo_we_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        div_err_o;

    div_issue_ctrl_if #(.DATA_W(32)) dif ();

    div_issue_ctrl #(
        .DATA_W(32),
        .TIMEOUT_CYCLES(48),
        .DIV_CONTROL(OP_DIV),
        .DIVU_CONTROL(OP_DIVU)
    ) dut (
        .clk(clk),
        .rst(rst),
        .op_i(op_i),
        .opdata1_i(opdata1_i),
        .opdata2_i(opdata2_i),
        .flush_i(flush_i),
        .div(dif.master),
        .stall_req_o(stall_req_o),
        .hilo_we_o(hilo_we_o),
        .hi_o(hi_o),
        .lo_o(lo_o),
        .div_err_o(div_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int writes = 0;
    logic [63:0] sb_q[$];
    logic force_nrdy = 1'b0;
    logic prev_we = 1'b0;
    int dcnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] div_model(input logic [5:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [31:0] sa, sb, sq, sr;
        logic [63:0] r;
        r = '0;
        if (b != 32'd0) begin
            if (op == OP_DIV) begin
                sa = a;
                sb = b;
                sq = sa / sb;
                sr = sa % sb;
                r = {sr, sq};
            end else begin
                r = {a % b, a / b};
            end
        end
        return r;
    endfunction

    // Behavioural divider: ready after 36 start cycles, or 4 for a zero divisor.
    always_ff @(posedge clk) begin
        if (!rst || !dif.div_start_o || dif.div_annul_o) dcnt <= 0;
        else dcnt <= dcnt + 1;
    end

    always_comb begin
        dif.div_ready_i  = 1'b0;
        dif.div_result_i = '0;
        if (dif.div_start_o && !force_nrdy &&
            dcnt == ((dif.div_opdata2_o == 32'd0) ? 3 : 35)) begin
            dif.div_ready_i  = 1'b1;
            dif.div_result_i = div_model(dif.div_op_o, dif.div_opdata1_o, dif.div_opdata2_o);
        end
    end

    always @(negedge clk) begin
        if (rst && hilo_we_o) begin
            logic [63:0] e;
            writes++;
            chk("we_pulse_width", {63'd0, prev_we}, 64'd0);
            if (sb_q.size() == 0) begin
                chk("unexpected_write", {32'd0, hi_o}, 64'hDEAD);
            end else begin
                e = sb_q.pop_front();
                chk("hi", {32'd0, hi_o}, {32'd0, e[63:32]});
                chk("lo", {32'd0, lo_o}, {32'd0, e[31:0]});
            end
        end
        prev_we = rst && hilo_we_o;
    end

    task automatic do_div(input bit skip, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input int exp_wait, input logic [5:0] nop, input logic [31:0] na,
                          input logic [31:0] nb);
        int stall_n = 0;
        int waitc = 0;
        bit got = 0;
        @(posedge clk); #1;
        if (!skip) begin
            op_i = op; opdata1_i = a; opdata2_i = b;
        end
        sb_q.push_back({eh, el});
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (c == 0) chk("start_t0", {63'd0, dif.div_start_o}, 64'd0);
            if (dif.div_start_o) waitc++;
            if (waitc == 1 && dif.div_start_o) begin
                chk("lat_op", {58'd0, dif.div_op_o}, {58'd0, op});
                chk("lat_a", {32'd0, dif.div_opdata1_o}, {32'd0, a});
                chk("lat_b", {32'd0, dif.div_opdata2_o}, {32'd0, b});
            end
            if (dif.div_ready_i) begin
                got = 1;
                chk("stall_rdy", {63'd0, stall_req_o}, 64'd0);
                chk("annul_rdy", {63'd0, dif.div_annul_o}, 64'd0);
                break;
            end
            if (stall_req_o) stall_n++;
            @(posedge clk); #1;
        end
        if (!got) chk("ready_timeout", 64'd0, 64'd1);
        chk("wait_len", 64'(waitc), 64'(exp_wait));
        chk("stall_len", 64'(stall_n), 64'(exp_wait));
        @(posedge clk); #1;
        op_i = nop; opdata1_i = na; opdata2_i = nb;
        @(negedge clk);
        chk("we_done", {63'd0, hilo_we_o}, 64'd1);
        chk("start_done", {63'd0, dif.div_start_o}, 64'd0);
        chk("stall_done", {63'd0, stall_req_o}, {63'd0, (nop == OP_DIV || nop == OP_DIVU)});
    endtask

    task automatic flush_at(input int n);
        @(posedge clk); #1;
        op_i = OP_DIVU; opdata1_i = 32'd8; opdata2_i = 32'd2;
        @(posedge clk); #1;
        for (int i = 1; i < n; i++) begin
            @(posedge clk); #1;
        end
        flush_i = 1'b1; op_i = OP_NOP;
        @(negedge clk);
        chk("flush_annul", {63'd0, dif.div_annul_o}, 64'd1);
        chk("flush_start", {63'd0, dif.div_start_o}, 64'd1);
        chk("flush_stall", {63'd0, stall_req_o}, 64'd0);
        if (n == 36) chk("flush_rdy_collide", {63'd0, dif.div_ready_i}, 64'd1);
        @(posedge clk); #1;
        flush_i = 1'b0;
        @(negedge clk);
        chk("flush_idle_start", {63'd0, dif.div_start_o}, 64'd0);
        chk("flush_no_we", {63'd0, hilo_we_o}, 64'd0);
    endtask

    initial begin
        int waitc;
        bit got;
        rst = 1'b0; op_i = OP_NOP; opdata1_i = '0; opdata2_i = '0; flush_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_start", {63'd0, dif.div_start_o}, 64'd0);
        chk("rst_annul", {63'd0, dif.div_annul_o}, 64'd0);
        chk("rst_stall", {63'd0, stall_req_o}, 64'd0);
        chk("rst_we", {63'd0, hilo_we_o}, 64'd0);
        chk("rst_hilo", {hi_o, lo_o}, 64'd0);
        chk("rst_err", {63'd0, div_err_o}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        do_div(0, OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 36, OP_NOP, 0, 0);
        do_div(0, OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 36, OP_NOP, 0, 0);
        do_div(0, OP_DIV, 32'd123, 32'd0, 32'd0, 32'd0, 4, OP_NOP, 0, 0);

        flush_at(10);
        do_div(0, OP_DIVU, 32'd9, 32'd3, 32'd0, 32'd3, 36, OP_NOP, 0, 0);
        flush_at(36);

        do_div(0, OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 36, OP_DIVU, 32'd50, 32'd5);
        do_div(1, OP_DIVU, 32'd50, 32'd5, 32'd0, 32'd10, 36, OP_NOP, 0, 0);

        force_nrdy = 1'b1;
        waitc = 0;
        got = 0;
        @(posedge clk); #1;
        op_i = OP_DIVU; opdata1_i = 32'd5; opdata2_i = 32'd1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (dif.div_start_o) waitc++;
            if (dif.div_annul_o) begin
                got = 1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("to_annul_seen", {63'd0, got}, 64'd1);
        chk("to_annul_cycle", 64'(waitc), 64'd48);
        chk("to_err_before", {63'd0, div_err_o}, 64'd0);
        @(posedge clk); #1;
        op_i = OP_NOP;
        force_nrdy = 1'b0;
        @(negedge clk);
        chk("to_idle_start", {63'd0, dif.div_start_o}, 64'd0);
        chk("to_err_set", {63'd0, div_err_o}, 64'd1);
        chk("to_no_we", {63'd0, hilo_we_o}, 64'd0);

        do_div(0, OP_DIVU, 32'd9, 32'd3, 32'd0, 32'd3, 36, OP_NOP, 0, 0);
        chk("err_sticky", {63'd0, div_err_o}, 64'd1);

        @(posedge clk); #1;
        op_i = OP_DIVU; opdata1_i = 32'd20; opdata2_i = 32'd3;
        repeat (6) begin
            @(posedge clk); #1;
        end
        rst = 1'b0; op_i = OP_NOP;
        @(negedge clk);
        chk("midrst_pre_start", {63'd0, dif.div_start_o}, 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_start", {63'd0, dif.div_start_o}, 64'd0);
        chk("midrst_err", {63'd0, div_err_o}, 64'd0);
        chk("midrst_hilo", {hi_o, lo_o}, 64'd0);
        chk("midrst_op", {58'd0, dif.div_op_o}, 64'd0);
        chk("midrst_opa", {32'd0, dif.div_opdata1_o}, 64'd0);
        chk("midrst_stall", {63'd0, stall_req_o}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);

        chk("n_writes", 64'(writes), 64'd7);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, bad=%0d", bad + 1);
        $fatal(1, "global timeout");
    end

endmodule
